target_box: RTL and testbench
=============================

# target_box

Per-frame colour-key target locator on the video pack stream, placed between white balance and the window-drawing stage. It passes the 50-bit pixel pack through with one register stage, finds every active pixel whose RGB falls inside a programmable inclusive box, and keeps the bounding rectangle of those pixels. At each frame boundary it publishes the rectangle as `start_x/start_y/end_x/end_y`, which feed the window-drawing stage's coordinate inputs directly.

## Interface
Parameters:
- `H_ACT`, 1280 — active width; matching x ≥ H_ACT is ignored.
- `V_ACT`, 720 — active height; matching y ≥ V_ACT is ignored.
- `MIN_PIXELS`, 64 — minimum matched-pixel count for a frame to yield a valid box.

Ports:
- `clk` in 1 — pixel clock, the same net as pack bit [49].
- `rstn` in 1 — synchronous, active-low reset.
- `i_pack` in 50 — layout: [49] clk, [48] hsync, [47] vsync (active high), [46] de, [45:38] r, [37:30] g, [29:22] b, [21:11] x, [10:0] y (y[10] unused).
- `o_pack` out 50 — `i_pack` delayed by one clock.
- `r_lo`, `r_hi`, `g_lo`, `g_hi`, `b_lo`, `b_hi` in 8 each — inclusive colour-key bounds.
- `start_x`, `end_x` out 11 — published box, x bounds.
- `start_y`, `end_y` out 10 — published box, y bounds.
- `box_valid` out 1 — the published box came from a frame that met `MIN_PIXELS`.
- `pix_count` out 20 — matched-pixel count of the last completed frame; saturates at 20'hFFFFF.

## Operation
- Frame boundary = `vs_edge` = `i_pack[47] & ~vs_q`, where `vs_q` is `i_pack[47]` registered.
- Key bounds are latched into shadow registers on every `vs_edge`. Matching uses only the shadow bounds, so bounds are constant within a frame.
- Match condition: `de` = 1, and `lo ≤ channel ≤ hi` for all three channels (unsigned), and x < H_ACT, and y[9:0] < V_ACT.
  - If lo > hi for any channel, nothing matches.
- Accumulators:
  - `min_x` init 11'h7FF, `max_x` init 0.
  - `min_y` init 10'h3FF, `max_y` init 0.
  - `cnt` init 0; a 20-bit saturating counter.
  - Each match updates min/max with compares against the current register values and increments `cnt`.
- State machine:
  - **IDLE** (after reset): accumulators are held at init. On `vs_edge`, latch bounds and go to ACCUM. This discards the partial first frame.
  - **ACCUM**: accumulate matches. On `vs_edge`, commit, then reinitialise the accumulators and stay in ACCUM.
- Commit action:
  - `pix_count` ← `cnt`.
  - If `cnt ≥ MIN_PIXELS`: the box outputs ← min/max values and `box_valid` ← 1.
  - Otherwise, see Configuration.
- A pixel with `de` = 1 in the same cycle as `vs_edge` is not counted.
- A vsync that stays high produces no further edges. No commit occurs until vsync falls and rises again.

## Timing
- `o_pack` latency is 1 clock, with no modification.
- Commit is registered on the clock edge at which `vs_edge` is true. Outputs are stable from the next cycle until the next commit.
- The last pixel counted in a frame is the one sampled on the edge just before `vs_edge`.
- Reset values:
  - `o_pack` = 0.
  - All box outputs = 0, `box_valid` = 0, `pix_count` = 0.
  - State = IDLE, `vs_q` = 0, shadow bounds = 0.
- Reset asserted mid-frame: all of the above apply at the next clock edge. The accumulated frame is lost, and the block resumes at the second `vs_edge` after release.
- Single-box example: box outputs follow the frame's pixels by one frame boundary.

## Configuration
- `TARGET_BOX_HOLD_EN` defined: a commit with `cnt < MIN_PIXELS` leaves the box outputs and `box_valid` unchanged (the last good target is held). `pix_count` still updates.
- Not defined: such a commit sets the box outputs to 0 and `box_valid` to 0.

## Test plan
- **Reset / passthrough:** hold `rstn`=0 for 4 clocks, then release. Expect all outputs 0. Then drive a ramp on `i_pack` and expect `o_pack` to equal `i_pack` delayed by 1.
- **Basic box:** key r 200–255, g 0–50, b 0–50. Paint a red 100×200 block at x=100..199, y=200..399 in a 1280×720 frame, bracketed by two vsync pulses after the first. Expect start=(100,200), end=(199,399), `box_valid`=1, `pix_count`=20000.
- **Below threshold:** 8 matching pixels with `MIN_PIXELS`=64. Without the macro, expect a 0 box and `box_valid`=0. With `TARGET_BOX_HOLD_EN`, expect the previous box held and `pix_count`=8.
- **Bound shadowing:** change `r_lo` from 200 to 0 mid-frame. Expect the current frame's result unaffected, and the following frame matching the new bounds.
- **Edge / boundary cases:**
  - A matching pixel at x=1279, y=719 gives end=(1279,719).
  - A matching pixel at x=1280 is ignored.
  - A matching pixel with `de`=1 on the `vs_edge` cycle is not counted.
  - lo > hi gives `pix_count`=0.
- **Mid-frame reset:** pulse `rstn` low during ACCUM. Expect the outputs cleared, no commit at the next vsync, and a valid box only after the second vsync edge.

Source files
------------

// File: rtl/target_box.sv
// ============================================================================
// Module      : target_box
// Description : Colour-key target locator. Passes the video pack through one
//               register stage and publishes, at each frame boundary, the
//               bounding box of all active pixels inside an RGB key box.
//               Optional macro TARGET_BOX_HOLD_EN holds the last good box when
//               a frame has too few matched pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module target_box #(
    parameter int H_ACT      = 1280,
    parameter int V_ACT      = 720,
    parameter int MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [49:0] i_pack,
    output logic [49:0] o_pack,
    input  logic [7:0]  r_lo,
    input  logic [7:0]  r_hi,
    input  logic [7:0]  g_lo,
    input  logic [7:0]  g_hi,
    input  logic [7:0]  b_lo,
    input  logic [7:0]  b_hi,
    output logic [10:0] start_x,
    output logic [9:0]  start_y,
    output logic [10:0] end_x,
    output logic [9:0]  end_y,
    output logic        box_valid,
    output logic [19:0] pix_count
);

    localparam logic [0:0]  c_ST_IDLE    = 1'b0;
    localparam logic [0:0]  c_ST_ACCUM   = 1'b1;
    localparam logic [11:0] c_H_ACT      = 12'(H_ACT);
    localparam logic [10:0] c_V_ACT      = 11'(V_ACT);
    localparam logic [20:0] c_MIN_PIXELS = 21'(MIN_PIXELS);
    localparam logic [10:0] c_MIN_X_INIT = 11'h7FF;
    localparam logic [9:0]  c_MIN_Y_INIT = 10'h3FF;
    localparam logic [19:0] c_CNT_MAX    = 20'hFFFFF;

    logic [0:0]  r_state;
    logic        r_vs_q;
    logic [7:0]  r_sh_r_lo, r_sh_r_hi;
    logic [7:0]  r_sh_g_lo, r_sh_g_hi;
    logic [7:0]  r_sh_b_lo, r_sh_b_hi;
    logic [10:0] r_min_x, r_max_x;
    logic [9:0]  r_min_y, r_max_y;
    logic [19:0] r_cnt;

    logic        w_vs;
    logic        w_de;
    logic [7:0]  w_r, w_g, w_b;
    logic [10:0] w_x;
    logic [9:0]  w_y;
    logic        w_vs_edge;
    logic        w_in_key;
    logic        w_in_active;
    logic        w_match;
    logic        w_enough;

    assign w_vs = i_pack[47];
    assign w_de = i_pack[46];
    assign w_r  = i_pack[45:38];
    assign w_g  = i_pack[37:30];
    assign w_b  = i_pack[29:22];
    assign w_x  = i_pack[21:11];
    assign w_y  = i_pack[9:0];

    assign w_vs_edge = w_vs & ~r_vs_q;

    // An inverted range (lo > hi) can never satisfy both compares
    assign w_in_key = (w_r >= r_sh_r_lo) && (w_r <= r_sh_r_hi) &&
                      (w_g >= r_sh_g_lo) && (w_g <= r_sh_g_hi) &&
                      (w_b >= r_sh_b_lo) && (w_b <= r_sh_b_hi);

    assign w_in_active = ({1'b0, w_x} < c_H_ACT) && ({1'b0, w_y} < c_V_ACT);
    assign w_match     = w_de && w_in_key && w_in_active;
    assign w_enough    = ({1'b0, r_cnt} >= c_MIN_PIXELS);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_pack    <= '0;
            r_vs_q    <= 1'b0;
            r_state   <= c_ST_IDLE;
            r_sh_r_lo <= '0;
            r_sh_r_hi <= '0;
            r_sh_g_lo <= '0;
            r_sh_g_hi <= '0;
            r_sh_b_lo <= '0;
            r_sh_b_hi <= '0;
            r_min_x   <= c_MIN_X_INIT;
            r_max_x   <= '0;
            r_min_y   <= c_MIN_Y_INIT;
            r_max_y   <= '0;
            r_cnt     <= '0;
            start_x   <= '0;
            start_y   <= '0;
            end_x     <= '0;
            end_y     <= '0;
            box_valid <= 1'b0;
            pix_count <= '0;
        end else begin
            o_pack <= i_pack;
            r_vs_q <= w_vs;

            if (w_vs_edge) begin
                r_sh_r_lo <= r_lo;
                r_sh_r_hi <= r_hi;
                r_sh_g_lo <= g_lo;
                r_sh_g_hi <= g_hi;
                r_sh_b_lo <= b_lo;
                r_sh_b_hi <= b_hi;
            end

            case (r_state)
                c_ST_IDLE: begin
                    // The partial frame seen after reset is discarded
                    r_min_x <= c_MIN_X_INIT;
                    r_max_x <= '0;
                    r_min_y <= c_MIN_Y_INIT;
                    r_max_y <= '0;
                    r_cnt   <= '0;
                    if (w_vs_edge) begin
                        r_state <= c_ST_ACCUM;
                    end
                end

                c_ST_ACCUM: begin
                    if (w_vs_edge) begin
                        pix_count <= r_cnt;
                        if (w_enough) begin
                            start_x   <= r_min_x;
                            start_y   <= r_min_y;
                            end_x     <= r_max_x;
                            end_y     <= r_max_y;
                            box_valid <= 1'b1;
                        end
`ifndef TARGET_BOX_HOLD_EN
                        else begin
                            start_x   <= '0;
                            start_y   <= '0;
                            end_x     <= '0;
                            end_y     <= '0;
                            box_valid <= 1'b0;
                        end
`endif
                        r_min_x <= c_MIN_X_INIT;
                        r_max_x <= '0;
                        r_min_y <= c_MIN_Y_INIT;
                        r_max_y <= '0;
                        r_cnt   <= '0;
                    end else if (w_match) begin
                        if (w_x < r_min_x) r_min_x <= w_x;
                        if (w_x > r_max_x) r_max_x <= w_x;
                        if (w_y < r_min_y) r_min_y <= w_y;
                        if (w_y > r_max_y) r_max_y <= w_y;
                        if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 20'd1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_target_box.sv
// ============================================================================
// Module      : tb_target_box
// Description : Self-checking bench for target_box: vector table of frames
//               plus directed multi-cycle sequences (shadowing, vs_edge pixel,
//               mid-frame reset). Expected values follow TARGET_BOX_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_target_box;

    logic        clk;
    logic        rstn;
    logic [49:0] i_pack;
    logic [49:0] o_pack;
    logic [7:0]  r_lo, r_hi, g_lo, g_hi, b_lo, b_hi;
    logic [10:0] start_x, end_x;
    logic [9:0]  start_y, end_y;
    logic        box_valid;
    logic [19:0] pix_count;

    int n_checks = 0;
    int n_errors = 0;

    target_box #(
        .H_ACT      (1280),
        .V_ACT      (720),
        .MIN_PIXELS (64)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_pack    (i_pack),
        .o_pack    (o_pack),
        .r_lo      (r_lo),
        .r_hi      (r_hi),
        .g_lo      (g_lo),
        .g_hi      (g_hi),
        .b_lo      (b_lo),
        .b_hi      (b_hi),
        .start_x   (start_x),
        .start_y   (start_y),
        .end_x     (end_x),
        .end_y     (end_y),
        .box_valid (box_valid),
        .pix_count (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rl, rh, gl, gh, bl, bh;
        logic [7:0]  cr, cg, cb;
        int          x0, x1, y0, y1;
        logic        stray;
        logic [10:0] sx, sy;
        logic [10:0] e_sx, e_ex;
        logic [9:0]  e_sy, e_ey;
        logic        e_v;
        logic [19:0] e_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One call = one pixel clock: inputs change on the falling edge
    task automatic drive(input logic vs, input logic de, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b,
                         input logic [10:0] x, input logic [10:0] y);
        @(negedge clk);
        i_pack = {1'b0, 1'b0, vs, de, r, g, b, x, y};
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0);
    endtask

    task automatic vs_pulse();
        drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0);
        idle();
    endtask

    task automatic paint(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                drive(1'b0, 1'b1, r, g, b, 11'(x), 11'(y));
            end
        end
        idle();
    endtask

    task automatic set_key(input logic [7:0] rl, input logic [7:0] rh, input logic [7:0] gl,
                           input logic [7:0] gh, input logic [7:0] bl, input logic [7:0] bh);
        @(negedge clk);
        r_lo = rl; r_hi = rh; g_lo = gl; g_hi = gh; b_lo = bl; b_hi = bh;
    endtask

    task automatic check_box(input string tag, input logic [10:0] sx, input logic [9:0] sy,
                             input logic [10:0] ex, input logic [9:0] ey,
                             input logic v, input logic [19:0] cnt);
        chk({tag, ".start_x"},   64'(start_x),   64'(sx));
        chk({tag, ".start_y"},   64'(start_y),   64'(sy));
        chk({tag, ".end_x"},     64'(end_x),     64'(ex));
        chk({tag, ".end_y"},     64'(end_y),     64'(ey));
        chk({tag, ".box_valid"}, 64'(box_valid), 64'(v));
        chk({tag, ".pix_count"}, 64'(pix_count), 64'(cnt));
    endtask

    task automatic fill_vectors();
        // basic red block, 100x200 = 20000 px
        vecs[0] = '{8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50, 8'd250, 8'd10, 8'd20,
                    100, 199, 200, 399, 1'b0, 11'd0, 11'd0,
                    11'd100, 11'd199, 10'd200, 10'd399, 1'b1, 20'd20000};
        // 8x8 block touching the last active column/row; stray at x=1280 ignored
        vecs[1] = '{8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50, 8'd220, 8'd0, 8'd0,
                    1272, 1279, 712, 719, 1'b1, 11'd1280, 11'd715,
                    11'd1272, 11'd1279, 10'd712, 10'd719, 1'b1, 20'd64};
        // 8 matching pixels: below threshold
        vecs[2] = '{8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50, 8'd255, 8'd50, 8'd0,
                    10, 17, 5, 5, 1'b0, 11'd0, 11'd0,
                    11'd0, 11'd0, 10'd0, 10'd0, 1'b0, 20'd8};
        // inverted red range: nothing matches
        vecs[3] = '{8'd100, 8'd50, 8'd0, 8'd50, 8'd0, 8'd50, 8'd75, 8'd10, 8'd10,
                    50, 57, 50, 57, 1'b0, 11'd0, 11'd0,
                    11'd0, 11'd0, 10'd0, 10'd0, 1'b0, 20'd0};
        // green channel out of key
        vecs[4] = '{8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50, 8'd250, 8'd51, 8'd0,
                    60, 67, 60, 67, 1'b0, 11'd0, 11'd0,
                    11'd0, 11'd0, 10'd0, 10'd0, 1'b0, 20'd0};
        // last row, stray at y=720 ignored
        vecs[5] = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd1, 8'd2, 8'd3,
                    0, 63, 719, 719, 1'b1, 11'd5, 11'd720,
                    11'd0, 11'd63, 10'd719, 10'd719, 1'b1, 20'd64};
`ifdef TARGET_BOX_HOLD_EN
        for (int i = 2; i <= 4; i++) begin
            vecs[i].e_sx = 11'd1272; vecs[i].e_ex = 11'd1279;
            vecs[i].e_sy = 10'd712;  vecs[i].e_ey = 10'd719;
            vecs[i].e_v  = 1'b1;
        end
`endif
    endtask

    initial begin
        logic [49:0] prev;
        logic [49:0] v;

        fill_vectors();
        rstn   = 1'b0;
        i_pack = '1;
        r_lo = 8'd200; r_hi = 8'd255; g_lo = 8'd0; g_hi = 8'd50; b_lo = 8'd0; b_hi = 8'd50;
        repeat (4) @(negedge clk);
        chk("reset.o_pack", 64'(o_pack), 64'd0);
        check_box("reset", 11'd0, 10'd0, 11'd0, 10'd0, 1'b0, 20'd0);

        // passthrough ramp
        rstn = 1'b1;
        prev = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k > 0) chk($sformatf("pass.o_pack[%0d]", k), 64'(o_pack), 64'(prev));
            v = 50'(k) * 50'h0_0F0F_0F0F_0F0F + 50'(k);
            i_pack = v;
            prev   = v;
        end

        // re-reset so the ramp's vsync activity leaves no trace
        @(negedge clk);
        rstn   = 1'b0;
        i_pack = '0;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            set_key(vecs[i].rl, vecs[i].rh, vecs[i].gl, vecs[i].gh, vecs[i].bl, vecs[i].bh);
            vs_pulse();
            paint(vecs[i].cr, vecs[i].cg, vecs[i].cb, vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
            if (vecs[i].stray) begin
                drive(1'b0, 1'b1, vecs[i].cr, vecs[i].cg, vecs[i].cb, vecs[i].sx, vecs[i].sy);
                idle();
            end
            vs_pulse();
            @(negedge clk);
            check_box($sformatf("vec%0d", i), vecs[i].e_sx, vecs[i].e_sy, vecs[i].e_ex,
                      vecs[i].e_ey, vecs[i].e_v, vecs[i].e_cnt);
        end

        // bound shadowing: r_lo changes mid-frame, takes effect next frame
        set_key(8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50);
        vs_pulse();
        paint(8'd230, 8'd0, 8'd0, 300, 307, 300, 307);
        r_lo = 8'd0;
        paint(8'd100, 8'd0, 8'd0, 400, 407, 400, 407);
        vs_pulse();
        @(negedge clk);
        check_box("shadow_a", 11'd300, 10'd300, 11'd307, 10'd307, 1'b1, 20'd64);
        paint(8'd100, 8'd0, 8'd0, 400, 407, 400, 407);
        vs_pulse();
        @(negedge clk);
        check_box("shadow_b", 11'd400, 10'd400, 11'd407, 10'd407, 1'b1, 20'd64);

        // matching pixel on the vs_edge cycle counts in neither frame
        set_key(8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50);
        vs_pulse();
        paint(8'd250, 8'd0, 8'd0, 500, 507, 500, 507);
        drive(1'b1, 1'b1, 8'd250, 8'd0, 8'd0, 11'd600, 11'd600);
        drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 11'd0, 11'd0);
        idle();
        @(negedge clk);
        check_box("vsde", 11'd500, 10'd500, 11'd507, 10'd507, 1'b1, 20'd64);
        vs_pulse();
        @(negedge clk);
        chk("vsde_next.pix_count", 64'(pix_count), 64'd0);

        // mid-frame reset
        vs_pulse();
        paint(8'd250, 8'd0, 8'd0, 700, 707, 100, 107);
        vs_pulse();
        @(negedge clk);
        check_box("mrst_pre", 11'd700, 10'd100, 11'd707, 10'd107, 1'b1, 20'd64);
        paint(8'd250, 8'd0, 8'd0, 700, 707, 100, 107);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mrst.o_pack", 64'(o_pack), 64'd0);
        check_box("mrst", 11'd0, 10'd0, 11'd0, 10'd0, 1'b0, 20'd0);
        paint(8'd250, 8'd0, 8'd0, 700, 707, 100, 107);
        vs_pulse();
        @(negedge clk);
        chk("mrst_first.box_valid", 64'(box_valid), 64'd0);
        chk("mrst_first.pix_count", 64'(pix_count), 64'd0);
        paint(8'd250, 8'd0, 8'd0, 710, 717, 110, 117);
        vs_pulse();
        @(negedge clk);
        check_box("mrst_second", 11'd710, 10'd110, 11'd717, 10'd117, 1'b1, 20'd64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
